// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter sharing one DATA_W-wide 2:1 select path
// between two requesters and a single valid/ready consumer. A grant is held
// for at most MAX_HOLD accepted beats while the other side is waiting.
// Optional build macro: MUX2_ARB_STATS_EN adds saturating per-requester
// accepted-beat counters on beats0/beats1 (tied to 0 when undefined).
module mux2_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4   // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] d0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d1,
    output logic              ack1,
    output logic [DATA_W-1:0] out1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              s0,
    output logic              busy,
    output logic [15:0]       beats0,
    output logic [15:0]       beats1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [7:0] hold, hold_nxt;
    logic       last, last_nxt;   // 1 = requester 1 was served last
    logic       granted;
    logic       own_req;
    logic       other_req;
    state_t     other_state;
    logic       xfer;

    // Decode of the current grant; a beat in a reset cycle is never accepted.
    assign granted     = (state != IDLE);
    assign own_req     = (state == G1) ? req1 : req0;
    assign other_req   = (state == G1) ? req0 : req1;
    assign other_state = (state == G1) ? G0 : G1;
    assign xfer        = granted & own_req & out_ready & ~rst;

    assign out_valid = granted & own_req & ~rst;
    assign ack0      = xfer & (state == G0);
    assign ack1      = xfer & (state == G1);
    assign out1      = s0 ? d1 : d0;
    assign busy      = granted;

    // Next-state, hold-budget and last-served pointer decisions.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_nxt = state;
        hold_nxt  = hold;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? G0 : G1;
                end else if (req0) begin
                    state_nxt = G0;
                end else if (req1) begin
                    state_nxt = G1;
                end
            end
            G0, G1: begin
                if (!own_req) begin
                    // Requester released: hand over or go idle.
                    state_nxt = other_req ? other_state : IDLE;
                    hold_nxt  = '0;
                    last_nxt  = (state == G1);
                end else if (xfer) begin
                    if (hold == HOLD_LAST) begin
                        // Budget exhausted: switch if the other side waits,
                        // otherwise keep the grant with a fresh budget.
                        hold_nxt = '0;
                        if (other_req) begin
                            state_nxt = other_state;
                            last_nxt  = (state == G1);
                        end
                    end else begin
                        hold_nxt = hold + 8'd1;
                    end
                end
                // No transfer: backpressure holds state and budget.
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // State register; s0 is registered so the select only moves on a clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments to avoid update-order races.
        if (rst) begin
            state <= IDLE;
            s0    <= 1'b0;
            hold  <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            s0    <= (state_nxt == G1);
            hold  <= hold_nxt;
            last  <= last_nxt;
        end
    end

`ifdef MUX2_ARB_STATS_EN
    // Saturating accepted-beat counters, one per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats0 <= '0;
            beats1 <= '0;
        end else begin
            if (ack0 && beats0 != 16'hFFFF) beats0 <= beats0 + 16'd1;
            if (ack1 && beats1 != 16'hFFFF) beats1 <= beats1 + 16'd1;
        end
    end
`else
    assign beats0 = '0;
    assign beats1 = '0;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: stimulus computes expected outputs
// from a grant/budget reference model and queues them; a monitor on the
// falling edge pops and compares against the DUT.
module tb_mux2_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst, req0, req1, out_ready;
    logic [DATA_W-1:0] d0, d1;
    logic              ack0, ack1, out_valid, s0, busy;
    logic [DATA_W-1:0] out1;
    logic [15:0]       beats0, beats1;

    mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .d0(d0), .ack0(ack0),
        .req1(req1), .d1(d1), .ack1(ack1),
        .out1(out1), .out_valid(out_valid), .out_ready(out_ready),
        .s0(s0), .busy(busy), .beats0(beats0), .beats1(beats1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ack0, ack1, valid, s0, busy;
        logic [DATA_W-1:0] out1;
        logic [15:0]       b0, b1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   seen_ack0 = 0;
    int   seen_ack1 = 0;

    // Reference model: owner of the path (-1 none), beats spent in this burst,
    // who was served last, and accepted-beat totals.
    int m_owner, m_used, m_last, m_cnt0, m_cnt1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_used = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // One clock cycle: drive inputs, queue expected outputs, advance the model.
    task automatic cycle(input logic r, input logic q0, input logic q1,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic rdy);
        exp_t e;
        logic rq[2];
        logic acc;
        rst = r; req0 = q0; req1 = q1; d0 = a; d1 = b; out_ready = rdy;
        rq[0] = q0; rq[1] = q1;
        e.busy  = (m_owner >= 0);
        e.s0    = (m_owner == 1);
        e.out1  = (m_owner == 1) ? b : a;
        e.valid = (m_owner >= 0) && rq[m_owner] && !r;
        acc     = e.valid && rdy;
        e.ack0  = acc && (m_owner == 0);
        e.ack1  = acc && (m_owner == 1);
`ifdef MUX2_ARB_STATS_EN
        e.b0 = 16'(m_cnt0);
        e.b1 = 16'(m_cnt1);
`else
        e.b0 = 16'd0;
        e.b1 = 16'd0;
`endif
        q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (e.ack0 && m_cnt0 < 65535) m_cnt0++;
            if (e.ack1 && m_cnt1 < 65535) m_cnt1++;
            if (m_owner < 0) begin
                if (q0 && q1)  m_owner = 1 - m_last;
                else if (q0)   m_owner = 0;
                else if (q1)   m_owner = 1;
            end else if (!rq[m_owner]) begin
                m_last  = m_owner;
                m_owner = rq[1 - m_owner] ? 1 - m_owner : -1;
                m_used  = 0;
            end else if (acc) begin
                m_used++;
                if (m_used == MAX_HOLD) begin
                    m_used = 0;
                    if (rq[1 - m_owner]) begin
                        m_last  = m_owner;
                        m_owner = 1 - m_owner;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (ack0) seen_ack0++;
            if (ack1) seen_ack1++;
            check("ack0",      32'(ack0),      32'(e.ack0));
            check("ack1",      32'(ack1),      32'(e.ack1));
            check("out_valid", 32'(out_valid), 32'(e.valid));
            check("s0",        32'(s0),        32'(e.s0));
            check("busy",      32'(busy),      32'(e.busy));
            check("out1",      32'(out1),      32'(e.out1));
            check("beats0",    32'(beats0),    32'(e.b0));
            check("beats1",    32'(beats1),    32'(e.b1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, wait_cnt;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset held then released, no requests.
        cycle(1, 0, 0, 8'h11, 8'h22, 1);
        repeat (5) cycle(0, 0, 0, 8'h11, 8'h22, 1);

        // Single requester streaming.
        repeat (6) cycle(0, 1, 0, 8'hA5, 8'h5A, 1);
        cycle(0, 0, 0, 8'hA5, 8'h5A, 1);
        cycle(1, 0, 0, 8'h00, 8'h00, 1);

        // Both continuously requesting: 4-beat alternating bursts.
        a0 = seen_ack0; a1 = seen_ack1;
        cycle(0, 1, 1, 8'h10, 8'h20, 1);            // IDLE -> G0
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, 8'(i), 8'(8'h80 + i), 1);
        check("burst_ack0_count", 32'(seen_ack0 - a0), 32'd8);
        check("burst_ack1_count", 32'(seen_ack1 - a1), 32'd8);
        cycle(1, 0, 0, 8'h00, 8'h00, 1);

        // Backpressure mid-burst in G0 with req1 waiting.
        cycle(0, 1, 0, 8'h31, 8'h41, 1);
        repeat (2) cycle(0, 1, 1, 8'h32, 8'h42, 1);
        repeat (6) cycle(0, 1, 1, 8'h33, 8'h43, 0);
        a0 = seen_ack0;
        repeat (3) cycle(0, 1, 1, 8'h34, 8'h44, 1);
        check("backpressure_ack0_after", 32'(seen_ack0 - a0), 32'd2);

        // req1 drops in G1 while req0 requests, then both idle.
        cycle(0, 0, 1, 8'h51, 8'h61, 1);
        cycle(0, 1, 0, 8'h52, 8'h62, 1);
        cycle(0, 1, 0, 8'h53, 8'h63, 1);
        repeat (2) cycle(0, 0, 0, 8'h54, 8'h64, 1);
        cycle(1, 0, 0, 8'h00, 8'h00, 1);

        // Stats: 10 beats from requester 0 then 7 from requester 1.
        cycle(0, 1, 0, 8'h01, 8'h02, 1);
        repeat (10) cycle(0, 1, 0, 8'h03, 8'h04, 1);
        cycle(0, 0, 1, 8'h05, 8'h06, 1);
        repeat (7) cycle(0, 0, 1, 8'h07, 8'h08, 1);
        cycle(0, 0, 0, 8'h09, 8'h0A, 1);
`ifdef MUX2_ARB_STATS_EN
        check("stats_beats0", 32'(beats0), 32'd10);
        check("stats_beats1", 32'(beats1), 32'd7);
`else
        check("stats_beats0_off", 32'(beats0), 32'd0);
        check("stats_beats1_off", 32'(beats1), 32'd0);
`endif
        // Reset mid-burst.
        repeat (3) cycle(0, 1, 1, 8'h0B, 8'h0C, 1);
        cycle(1, 1, 1, 8'h0D, 8'h0E, 1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beats0", 32'(beats0), 32'd0);

        // Randomized traffic, occasional reset.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        cycle(0, 0, 0, 8'h00, 8'h00, 1);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
